divider_32bit: RTL

- Iterative radix-2 restoring divider, the inverse operation to the team's pipelined Booth multiplier.
- Computes a 32-bit quotient and remainder, signed or unsigned, one quotient bit per clock.
- Uses a start/busy/done handshake and holds registered results until the next start.
- Sits beside the multiplier in the arithmetic unit; shares its operand and result buses.

---
 rtl/divider_32bit_pkg.sv | 28 ++
 rtl/divider_32bit_step.sv | 38 +++
 rtl/divider_32bit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/divider_32bit_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package divider_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } div_state_t;

    // Magnitude of a DIV_WIDTH-bit operand; unsigned operands pass through.
    // |MIN| = 2^(DIV_WIDTH-1) is representable because the result is unsigned.
    function automatic logic [DIV_WIDTH-1:0] abs_val(
        input logic [DIV_WIDTH-1:0] value,
        input logic                 is_signed
    );
        logic [DIV_WIDTH-1:0] result;
        if (is_signed && value[DIV_WIDTH-1]) begin
            result = ~value + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/divider_32bit_step.sv
// One restoring-division iteration: shift {P, A} left, try to subtract the
// divisor from P, and record the outcome as the new quotient bit.
module divider_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   p_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH:0]   p_o,
    output logic [WIDTH-1:0] a_o
);

    logic [2*WIDTH:0] pa_sh_s;
    logic [WIDTH:0]   p_sh_s;
    logic [WIDTH-1:0] a_sh_s;
    logic [WIDTH+1:0] diff_s;

    // Shift the concatenated partial remainder/quotient and form the trial difference.
    always_comb begin
        pa_sh_s = {p_i, a_i} << 1;
        p_sh_s  = pa_sh_s[2*WIDTH:WIDTH];
        a_sh_s  = pa_sh_s[WIDTH-1:0];
        // One extra bit so the sign of the trial subtraction is visible.
        diff_s  = {1'b0, p_sh_s} - {2'b00, d_i};
    end

    // Keep the difference when it is non-negative, otherwise restore P.
    always_comb begin
        if (diff_s[WIDTH+1] == 1'b0) begin
            p_o = diff_s[WIDTH:0];
            a_o = a_sh_s | {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            p_o = p_sh_s;
            a_o = a_sh_s;
        end
    end

endmodule

// File: rtl/divider_32bit.sv
// Iterative radix-2 restoring divider, signed or unsigned, one quotient bit
// per clock. start/busy/done handshake; results held until the next start.
module divider_32bit
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] W_ONES   = {WIDTH{1'b1}};

    div_state_t       state_q,     state_d;
    logic [CW-1:0]    count_q,     count_d;
    logic [WIDTH:0]   p_q,         p_d;
    logic [WIDTH-1:0] a_q,         a_d;
    logic [WIDTH-1:0] dvsr_q,      dvsr_d;
    logic             quot_neg_q,  quot_neg_d;
    logic             rem_neg_q,   rem_neg_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;
    logic [WIDTH-1:0] quotient_q,  quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;

    logic [WIDTH-1:0] in0_mag_s;
    logic [WIDTH-1:0] in1_mag_s;
    logic [WIDTH:0]   step_p_s;
    logic [WIDTH-1:0] step_a_s;

    // Operand magnitudes: the shared package helper covers the native width,
    // other widths use the same rule locally.
    generate
        if (WIDTH == DIV_WIDTH) begin : g_pkg_abs
            assign in0_mag_s = abs_val(in0, is_signed);
            assign in1_mag_s = abs_val(in1, is_signed);
        end else begin : g_local_abs
            assign in0_mag_s = (is_signed && in0[WIDTH-1]) ? (~in0 + W_ONE) : in0;
            assign in1_mag_s = (is_signed && in1[WIDTH-1]) ? (~in1 + W_ONE) : in1;
        end
    endgenerate

    divider_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .p_i (p_q),
        .a_i (a_q),
        .d_i (dvsr_q),
        .p_o (step_p_s),
        .a_o (step_a_s)
    );

    // Next-state and datapath: busy/done are computed for the state being entered.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        p_d         = p_q;
        a_d         = a_q;
        dvsr_d      = dvsr_q;
        quot_neg_d  = quot_neg_q;
        rem_neg_d   = rem_neg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (in1 == W_ZERO) begin
                        // Divide by zero finishes immediately with a fixed result.
                        quotient_d  = W_ONES;
                        remainder_d = in0;
                        done_d      = 1'b1;
                        state_d     = DONE;
                    end else begin
                        quot_neg_d = is_signed & (in0[WIDTH-1] ^ in1[WIDTH-1]);
                        rem_neg_d  = is_signed & in0[WIDTH-1];
                        a_d        = in0_mag_s;
                        dvsr_d     = in1_mag_s;
                        p_d        = {(WIDTH+1){1'b0}};
                        count_d    = CNT_INIT;
                        busy_d     = 1'b1;
                        state_d    = CALC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                p_d    = step_p_s;
                a_d    = step_a_s;
                busy_d = 1'b1;
                if (count_q == {CW{1'b0}}) begin
                    state_d = FIX;
                end else begin
                    count_d = count_q - CNT_ONE;
                end
            end
            FIX: begin
                // Quotient truncates toward zero; remainder takes the dividend's sign.
                quotient_d  = quot_neg_q ? (~a_q + W_ONE) : a_q;
                remainder_d = rem_neg_q ? (~p_q[WIDTH-1:0] + W_ONE) : p_q[WIDTH-1:0];
                done_d      = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any operation without a done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            count_q     <= {CW{1'b0}};
            p_q         <= {(WIDTH+1){1'b0}};
            a_q         <= W_ZERO;
            dvsr_q      <= W_ZERO;
            quot_neg_q  <= 1'b0;
            rem_neg_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= W_ZERO;
            remainder_q <= W_ZERO;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            p_q         <= p_d;
            a_q         <= a_d;
            dvsr_q      <= dvsr_d;
            quot_neg_q  <= quot_neg_d;
            rem_neg_q   <= rem_neg_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule
